// File: rtl/axilregs_pkg.sv
// Shared definitions for the UART-to-AXI-Lite command bridge.
package axilregs_pkg;

  localparam logic [7:0] CMD_WR     = 8'h57;
  localparam logic [7:0] CMD_RD     = 8'h52;
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_BADCMD = 8'h3F;

  localparam int unsigned RSP_MAX_BYTES = 5;
  localparam int unsigned RSP_LEN_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WR_BUS,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_TX
  } state_t;

  // Response frame: bytes[0] goes out first, len counts valid bytes (1..5).
  typedef struct packed {
    logic [RSP_LEN_W-1:0]                len;
    logic [RSP_MAX_BYTES-1:0][7:0]       bytes;
  } rsp_frame_t;

  // Map an AXI-Lite xRESP onto the status byte.
  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return (resp == 2'b00) ? RSP_OK : RSP_ERR;
  endfunction

endpackage

// File: rtl/rsp_serializer.sv
// Emits a loaded response frame byte by byte on an AXI-Stream source.
module rsp_serializer
  import axilregs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_c,
  input  rsp_frame_t frame_c,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready,
  output logic       tlast
);

  logic [RSP_MAX_BYTES-1:0][7:0] pend_q;
  logic [RSP_LEN_W-1:0]          left_q;

  // Current byte sits on tdata; pend_q holds the rest, left_q counts them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      pend_q <= '0;
      left_q <= '0;
    end else if (load_c) begin
      tdata  <= frame_c.bytes[0];
      pend_q <= frame_c.bytes >> 8;
      left_q <= frame_c.len - RSP_LEN_W'(1);
      tvalid <= 1'b1;
      tlast  <= (frame_c.len == RSP_LEN_W'(1));
    end else if (tvalid && tready) begin
      if (left_q == '0) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end else begin
        tdata  <= pend_q[0];
        pend_q <= pend_q >> 8;
        left_q <= left_q - RSP_LEN_W'(1);
        tlast  <= (left_q == RSP_LEN_W'(1));
      end
    end
  end

endmodule

// File: rtl/axis_axil_master.sv
// Byte-stream command parser driving single-beat AXI-Lite writes and reads.
module axis_axil_master
  import axilregs_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  input  logic [1:0]          m_axil_bresp,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  input  logic [7:0]          s_axis_cmd_tdata,
  input  logic                s_axis_cmd_tvalid,
  output logic                s_axis_cmd_tready,
  output logic [7:0]          m_axis_rsp_tdata,
  output logic                m_axis_rsp_tvalid,
  input  logic                m_axis_rsp_tready,
  output logic                m_axis_rsp_tlast,
  output logic                o_busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_n;
  logic                mode_wr_q, mode_wr_n;
  logic [7:0]          addr_q, addr_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [1:0]          bcnt_q, bcnt_n;
  logic [TMO_W-1:0]    tmo_q, tmo_n;
  logic                awvalid_q, awvalid_n, wvalid_q, wvalid_n, arvalid_q, arvalid_n;
  logic                bready_q, bready_n, rready_q, rready_n;
  logic                tready_q, tready_n, busy_q, busy_n;
  logic                cmd_hs, tmo_expired;
  logic                load_c;
  rsp_frame_t          frame_c;

  assign cmd_hs      = s_axis_cmd_tvalid && tready_q;
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  assign m_axil_awaddr     = ADDR_W'(addr_q);
  assign m_axil_araddr     = ADDR_W'(addr_q);
  assign m_axil_awprot     = 3'b000;
  assign m_axil_arprot     = 3'b000;
  assign m_axil_wstrb      = '1;
  assign m_axil_wdata      = data_q;
  assign m_axil_awvalid    = awvalid_q;
  assign m_axil_wvalid     = wvalid_q;
  assign m_axil_arvalid    = arvalid_q;
  assign m_axil_bready     = bready_q;
  assign m_axil_rready     = rready_q;
  assign s_axis_cmd_tready = tready_q;
  assign o_busy            = busy_q;

  // State and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_wr_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      mode_wr_q <= mode_wr_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      bcnt_q    <= bcnt_n;
      tmo_q     <= tmo_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      arvalid_q <= arvalid_n;
      bready_q  <= bready_n;
      rready_q  <= rready_n;
      tready_q  <= tready_n;
      busy_q    <= busy_n;
    end
  end

  // Command parsing, bus sequencing and response loading.
  always_comb begin
    state_n   = state_q;
    mode_wr_n = mode_wr_q;
    addr_n    = addr_q;
    data_n    = data_q;
    bcnt_n    = bcnt_q;
    tmo_n     = '0;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    arvalid_n = arvalid_q;
    bready_n  = bready_q;
    rready_n  = rready_q;
    load_c    = 1'b0;
    frame_c   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          if (s_axis_cmd_tdata == CMD_WR) begin
            mode_wr_n = 1'b1;
            state_n   = ST_ADDR;
          end else if (s_axis_cmd_tdata == CMD_RD) begin
            mode_wr_n = 1'b0;
            state_n   = ST_ADDR;
          end else begin
            load_c           = 1'b1;
            frame_c.len      = RSP_LEN_W'(1);
            frame_c.bytes[0] = RSP_BADCMD;
            state_n          = ST_TX;
          end
        end
      end
      ST_ADDR: begin
        if (cmd_hs) begin
          addr_n = s_axis_cmd_tdata;
          if (mode_wr_q) begin
            bcnt_n  = '0;
            state_n = ST_WDATA;
          end else begin
            arvalid_n = 1'b1;
            state_n   = ST_RD_ADDR;
          end
        end else if (tmo_expired) begin
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end
      ST_WDATA: begin
        if (cmd_hs) begin
          data_n = {s_axis_cmd_tdata, data_q[DATA_W-1:8]};
          bcnt_n = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = ST_WR_BUS;
          end
        end else if (tmo_expired) begin
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end
      ST_WR_BUS: begin
        awvalid_n = awvalid_q && !m_axil_awready;
        wvalid_n  = wvalid_q && !m_axil_wready;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          state_n  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axil_bvalid && bready_q) begin
          bready_n      = 1'b0;
          load_c        = 1'b1;
          frame_c.len   = RSP_LEN_W'(1);
          frame_c.bytes = {32'h0, status_byte(m_axil_bresp)};
          state_n       = ST_TX;
        end
      end
      ST_RD_ADDR: begin
        if (m_axil_arready && arvalid_q) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axil_rvalid && rready_q) begin
          rready_n      = 1'b0;
          load_c        = 1'b1;
          frame_c.len   = RSP_LEN_W'(5);
          frame_c.bytes = {32'(m_axil_rdata), status_byte(m_axil_rresp)};
          state_n       = ST_TX;
        end
      end
      ST_TX: begin
        if (m_axis_rsp_tvalid && m_axis_rsp_tready && m_axis_rsp_tlast) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    tready_n = (state_n == ST_IDLE) || (state_n == ST_ADDR) || (state_n == ST_WDATA);
    busy_n   = (state_n != ST_IDLE);
  end

  // Response byte stream.
  rsp_serializer u_rsp (
    .clk     (clk),
    .rst     (rst),
    .load_c  (load_c),
    .frame_c (frame_c),
    .tdata   (m_axis_rsp_tdata),
    .tvalid  (m_axis_rsp_tvalid),
    .tready  (m_axis_rsp_tready),
    .tlast   (m_axis_rsp_tlast)
  );

endmodule

// File: tb/tb_axis_axil_master.sv
// Randomized bench for axis_axil_master with an AXI-Lite slave and frame-level reference model.
module tb_axis_axil_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 20;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [7:0] cmd_tdata, rsp_tdata;
  logic cmd_tvalid, cmd_tready, rsp_tvalid, rsp_tready, rsp_tlast, busy;

  // Test configuration (owned by the main sequence).
  int          aw_delay, ar_delay;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        rsp_hold, bp_rand;

  // Slave-side observations (owned by the slave process).
  logic [31:0] smem [64];
  logic        aw_have, w_have, ar_have;
  logic [31:0] aw_addr, w_data, ar_addr;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [2:0]  last_awprot;
  logic [3:0]  last_wstrb;
  logic [8:0]  rsp_q [$];

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [8:0]  exp_q [$];
  logic [7:0]  txq [$];
  int          rsp_rd;
  int          n_tests, n_fail;

  always #5 clk = ~clk;

  axis_axil_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .s_axis_cmd_tdata(cmd_tdata), .s_axis_cmd_tvalid(cmd_tvalid), .s_axis_cmd_tready(cmd_tready),
    .m_axis_rsp_tdata(rsp_tdata), .m_axis_rsp_tvalid(rsp_tvalid), .m_axis_rsp_tready(rsp_tready),
    .m_axis_rsp_tlast(rsp_tlast), .o_busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // AXI-Lite slave: handshakes sampled at posedge, responses driven at negedge.
  initial begin : slave
    int aw_wait, ar_wait;
    aw_wait = 0; ar_wait = 0;
    aw_have = 0; w_have = 0; ar_have = 0; aw_addr = 0; w_data = 0; ar_addr = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    last_awaddr = 0; last_wdata = 0; last_araddr = 0; last_awprot = 0; last_wstrb = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    rsp_tready = 0;
    for (int i = 0; i < 64; i++) smem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (rst) begin
        aw_have = 0; w_have = 0; ar_have = 0;
      end else begin
        if (awvalid && awready) begin
          aw_have = 1; aw_addr = awaddr; aw_cnt++; last_awaddr = awaddr; last_awprot = awprot;
        end
        if (wvalid && wready) begin
          w_have = 1; w_data = wdata; w_cnt++; last_wdata = wdata; last_wstrb = wstrb;
        end
        if (bvalid && bready) begin
          if (bresp == 2'b00) smem[aw_addr[7:2]] = w_data;
          aw_have = 0; w_have = 0;
        end
        if (arvalid && arready) begin
          ar_have = 1; ar_addr = araddr; ar_cnt++; last_araddr = araddr;
        end
        if (rvalid && rready) ar_have = 0;
        if (rsp_tvalid && rsp_tready) rsp_q.push_back({rsp_tlast, rsp_tdata});
      end
      @(negedge clk);
      if (rst || !awvalid) aw_wait = 0;
      awready = awvalid && !aw_have && (aw_wait >= aw_delay);
      if (awvalid && !awready) aw_wait++;
      wready = wvalid && !w_have;
      bvalid = aw_have && w_have;
      bresp  = bresp_cfg;
      if (rst || !arvalid) ar_wait = 0;
      arready = arvalid && !ar_have && (ar_wait >= ar_delay);
      if (arvalid && !arready) ar_wait++;
      rvalid = ar_have;
      rdata  = smem[ar_addr[7:2]];
      rresp  = rresp_cfg;
      rsp_tready = rsp_hold ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Push txq onto the command stream, one byte per handshake.
  task automatic send_all();
    while (txq.size() > 0) begin
      int guard = 0;
      @(negedge clk);
      cmd_tdata  = txq[0];
      cmd_tvalid = 1'b1;
      do begin
        @(posedge clk);
        guard++;
      end while (!cmd_tready && guard < 300);
      if (!cmd_tready) begin
        check("cmd_accept", 32'(cmd_tready), 32'd1);
        txq.delete();
      end else begin
        void'(txq.pop_front());
      end
    end
    @(negedge clk);
    cmd_tvalid = 1'b0;
  endtask

  // Wait for the frame and compare it byte by byte (tlast in bit 8).
  task automatic expect_rsp();
    int guard = 0;
    while (((rsp_q.size() - rsp_rd) < exp_q.size() || busy) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("rsp_len", 32'(rsp_q.size() - rsp_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (rsp_rd + i < rsp_q.size())
        check($sformatf("rsp_byte%0d", i), 32'(rsp_q[rsp_rd + i]), 32'(exp_q[i]));
    rsp_rd = rsp_q.size();
  endtask

  task automatic model_read(input logic [7:0] a);
    logic [31:0] d;
    d   = ref_mem[a[7:2]];
    txq = '{8'h52, a};
    exp_q.delete();
    exp_q.push_back({1'b0, (rresp_cfg == 2'b00) ? 8'h4B : 8'h45});
    exp_q.push_back({1'b0, d[7:0]});
    exp_q.push_back({1'b0, d[15:8]});
    exp_q.push_back({1'b0, d[23:16]});
    exp_q.push_back({1'b1, d[31:24]});
  endtask

  task automatic do_read(input logic [7:0] a);
    int ar0;
    ar0 = ar_cnt;
    model_read(a);
    send_all();
    expect_rsp();
    check("ar_count", 32'(ar_cnt - ar0), 32'd1);
    check("araddr", last_araddr, {24'h0, a});
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    txq = '{8'h57, a, d[7:0], d[15:8], d[23:16], d[31:24]};
    exp_q.delete();
    exp_q.push_back({1'b1, (bresp_cfg == 2'b00) ? 8'h4B : 8'h45});
    if (bresp_cfg == 2'b00) ref_mem[a[7:2]] = d;
    send_all();
    expect_rsp();
    check("aw_count", 32'(aw_cnt - aw0), 32'd1);
    check("w_count", 32'(w_cnt - w0), 32'd1);
    check("awaddr", last_awaddr, {24'h0, a});
    check("wdata", last_wdata, d);
    check("wstrb", 32'(last_wstrb), 32'hF);
  endtask

  task automatic do_bad(input logic [7:0] op);
    int aw0, ar0;
    aw0 = aw_cnt; ar0 = ar_cnt;
    txq = '{op};
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h3F});
    send_all();
    expect_rsp();
    check("bad_no_aw", 32'(aw_cnt - aw0), 32'd0);
    check("bad_no_ar", 32'(ar_cnt - ar0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_awvalid"}, 32'(awvalid), 32'd0);
    check({pfx, "_wvalid"}, 32'(wvalid), 32'd0);
    check({pfx, "_arvalid"}, 32'(arvalid), 32'd0);
    check({pfx, "_bready"}, 32'(bready), 32'd0);
    check({pfx, "_rready"}, 32'(rready), 32'd0);
    check({pfx, "_cmd_tready"}, 32'(cmd_tready), 32'd0);
    check({pfx, "_rsp_tvalid"}, 32'(rsp_tvalid), 32'd0);
    check({pfx, "_rsp_tdata"}, 32'(rsp_tdata), 32'd0);
    check({pfx, "_rsp_tlast"}, 32'(rsp_tlast), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    int aw0, guard;
    logic [7:0] a, op;
    n_tests = 0; n_fail = 0; rsp_rd = 0;
    rst = 1'b1; cmd_tdata = 8'h00; cmd_tvalid = 1'b0;
    aw_delay = 0; ar_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; rsp_hold = 1'b0; bp_rand = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_cmd_tready", 32'(cmd_tready), 32'd1);

    // Basic write, readback and the 0xDEADBEEF read.
    do_write(8'h00, 32'h0000_000F);
    check("awprot", 32'(last_awprot), 32'd0);
    do_read(8'h00);
    do_write(8'h1C, 32'hDEAD_BEEF);
    do_read(8'h1C);

    // Error responses and unknown opcode.
    bresp_cfg = 2'b10;
    do_write(8'h20, 32'h1234_5678);
    bresp_cfg = 2'b00;
    do_read(8'h20);
    rresp_cfg = 2'b10;
    do_read(8'h1C);
    rresp_cfg = 2'b00;
    do_bad(8'h41);
    do_read(8'h00);

    // Partial write abandoned by the inter-byte timeout.
    aw0 = aw_cnt;
    txq = '{8'h57, 8'h1C, 8'h11};
    send_all();
    repeat (3) @(negedge clk);
    check("tmo_busy_pending", 32'(busy), 32'd1);
    repeat (TMO + 5) @(negedge clk);
    check("tmo_busy_idle", 32'(busy), 32'd0);
    check("tmo_no_aw", 32'(aw_cnt - aw0), 32'd0);
    check("tmo_no_rsp", 32'(rsp_q.size() - rsp_rd), 32'd0);
    do_read(8'h00);

    // Response sink stalled for 50 cycles in the middle of a read.
    rsp_hold = 1'b1;
    model_read(8'h1C);
    send_all();
    guard = 0;
    while (!rsp_tvalid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_tvalid !== 1'b1 || rsp_tdata !== 8'h4B || cmd_tready !== 1'b0)
        check("bp_hold", {23'h0, rsp_tvalid, rsp_tdata}, {23'h0, 1'b1, 8'h4B});
    end
    check("bp_tvalid", 32'(rsp_tvalid), 32'd1);
    check("bp_tdata", 32'(rsp_tdata), 32'h4B);
    check("bp_tlast", 32'(rsp_tlast), 32'd0);
    check("bp_cmd_tready", 32'(cmd_tready), 32'd0);
    rsp_hold = 1'b0;
    expect_rsp();

    // AW accepted three cycles after W.
    aw_delay = 3;
    do_write(8'h30, 32'hCAFE_0042);
    aw_delay = 0;
    do_read(8'h30);

    // Randomized mix with random response backpressure.
    bp_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 63)) << 2;
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      aw_delay  = $urandom_range(0, 3);
      if (sel < 4) begin
        do_write(a, $urandom);
      end else if (sel < 9) begin
        do_read(a);
      end else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
        do_bad(op);
      end
    end
    bp_rand = 1'b0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; aw_delay = 0;

    // Reset while AR is still waiting for arready.
    ar_delay = 30;
    txq = '{8'h52, 8'h04};
    send_all();
    guard = 0;
    while (!arvalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_arvalid", 32'(arvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    ar_delay = 0;
    repeat (3) @(negedge clk);
    rsp_rd = rsp_q.size();
    do_read(8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_axil_master.md
Name: axis_axil_master

Overview:
- Synthesizable AXI-Lite initiator that lets a host drive the register slave over the UART byte path.
- Parses 8-bit command frames from an AXI-Stream sink and performs single-beat AXI-Lite writes and reads.
- Returns status and read data as 8-bit frames on an AXI-Stream source.
- Sits between the UART RX/TX byte streams and axil_regs, the same slave exercised by the register bench.

Parameters:
- ADDR_W, 32: AXI-Lite address width; the command address byte is zero-extended to this width.
- DATA_W, 32: AXI-Lite data width; fixed at 32, 4 data bytes per frame.
- TIMEOUT_CYCLES, 100000: inter-byte idle limit in cycles before a partial command is discarded; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m_axil_wr  taxi_axil_if.wr_mst  -  AXI-Lite write master (AW/W/B).
- m_axil_rd  taxi_axil_if.rd_mst  -  AXI-Lite read master (AR/R).
- s_axis_cmd  taxi_axis_if.snk  8  command bytes from UART RX.
- m_axis_rsp  taxi_axis_if.src  8  response bytes to UART TX; tlast set on the final byte of each response.
- o_busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values: all valid signals 0, bready 0, rready 0, cmd tready 0, rsp tdata 0, tlast 0, o_busy 0, state IDLE, timeout counter 0.
- On reset assertion mid-transaction, the FSM aborts immediately with no completion or response.
- Command frames:
  - Write: 0x57 ('W'), ADDR, D0, D1, D2, D3. Data is little-endian, D0 = bits 7:0.
  - Read: 0x52 ('R'), ADDR.
- Response frames:
  - Write: one status byte.
  - Read: status byte, then D0..D3 little-endian, 5 bytes total. Data bytes are sent even when the status is error.
  - Status byte: 0x4B ('K') for xRESP = OKAY; 0x45 ('E') otherwise.
  - Unknown opcode: single byte 0x3F ('?'); the opcode byte is consumed.
- States: IDLE, ADDR, WDATA, WR_BUS, WR_RESP, RD_ADDR, RD_DATA, TX.
- IDLE: cmd tready=1.
  - On handshake: 'W' → ADDR (mode write); 'R' → ADDR (mode read); other → TX with '?'.
- ADDR: tready=1; latch the address byte.
  - Write mode → WDATA with byte count 0; read mode → RD_ADDR.
- WDATA: tready=1; shift in 4 bytes, count 0..3. After byte 3 → WR_BUS.
- WR_BUS:
  - Asserts awvalid and wvalid together in the same cycle. wstrb=4'hF, awprot=0.
  - Each valid is deasserted independently on its own handshake.
  - Address and data are held stable until their handshake completes.
  - When both channels are done → WR_RESP.
- WR_RESP: bready=1; on bvalid, capture bresp → TX.
- RD_ADDR: arvalid=1, arprot=0; on arready → RD_DATA.
- RD_DATA: rready=1; on rvalid, capture rdata and rresp → TX.
- TX:
  - Drives response bytes in order; each byte is held until tready.
  - tlast=1 only on the last byte.
  - After the last handshake → IDLE.
  - cmd tready=0 throughout TX, WR_*, RD_*; input is back-pressured, never dropped.
- Inter-byte timeout:
  - The counter runs only in ADDR and WDATA and clears on every cmd handshake.
  - When it reaches TIMEOUT_CYCLES: → IDLE silently, no bus access, no response.
  - No timeout in bus or TX states; the slave and TX sink are trusted to respond.
- Latency: the first AW/W/AR valid asserts the cycle after the final command byte handshake. The first response byte is valid the cycle after the B/R handshake.
- Only one outstanding transaction at any time. Address zero-extension: awaddr/araddr = {(ADDR_W-8)'0, ADDR}.

Decomposition:
- Shared package axilregs_pkg gains:
  - opcode constants CMD_WR=8'h57, CMD_RD=8'h52;
  - status constants RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BADCMD=8'h3F;
  - the FSM state enum type.
- Sub-module rsp_serializer: loads up to 5 bytes plus a length and emits them as AXI-Stream with tlast. It is the only natural split; the parser and bus FSM stay in the top.

Test Plan:
- Write: cmd 57 00 0F 00 00 00 → one AW/W with awaddr=0x00, wdata=0x0000000F, wstrb=F; bresp=0 → rsp 4B with tlast=1; axil_regs o_cr1 reads back 0x0000000F.
- Read: cmd 52 1C, slave rdata=0xDEADBEEF, rresp=0 → araddr=0x1C; rsp 4B EF BE AD DE, tlast only on DE.
- Error and bad opcode: slave bresp=2'b10 on write → rsp 45; cmd byte 41 → rsp 3F, no AXI activity, next valid command is processed normally.
- Timeout: cmd 57 1C 11, then idle TIMEOUT_CYCLES cycles → no AW/W, back to IDLE, o_busy=0; a following 52 00 completes correctly.
- Backpressure: rsp tready=0 for 50 cycles during a read → response byte held stable and cmd tready=0; AW and W accepted in different cycles (awready delayed 3 cycles) → exactly one write.
- Reset mid-read while arvalid=1 → all outputs at reset values next cycle; a fresh 52 00 after release returns a correct 5-byte frame.
